// File: rtl/lsu_mem_pkg.sv
// Shared types and helpers for the LSU memory responder: default widths,
// the queued-request layout, the head FSM states and the byte-enable merge.
package lsu_mem_pkg;

    localparam int LSU_NUM_WORDS = 32;
    localparam int LSU_DATA_W    = 32;
    localparam int LSU_ADDR_W    = 32;
    localparam int LSU_LAT_W     = 3;
    localparam int LSU_BE_W      = LSU_DATA_W / 8;

    // Layout of one queued request; the FIFO entry vector uses the same
    // field order (we is the MSB, lat the LSBs).
    typedef struct packed {
        logic                  we;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
        logic [LSU_BE_W-1:0]   be;
        logic [LSU_LAT_W-1:0]  lat;
    } lsu_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [LSU_DATA_W-1:0] be_merge(
        input logic [LSU_DATA_W-1:0] old_word,
        input logic [LSU_DATA_W-1:0] new_word,
        input logic [LSU_BE_W-1:0]   be
    );
        logic [LSU_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < LSU_BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// Two-entry in-order request FIFO. Pointers and occupancy are reset;
// the payload slots are plain storage and only written on push.
module lsu_req_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] slots [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    // Pointer and occupancy tracking; push and pop may happen together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage, written at the tail slot on push.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= din;
        end
    end

    assign dout  = slots[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/lsu_mem_responder.sv
// Data-memory responder for the CVA6 LSU shim. Accepts load/store requests
// into a 2-entry in-order queue, waits a per-request latency, then emits a
// single-cycle load or store completion pulse while committing the access to
// a small word-addressed memory.
// Build option: LSU_MEM_RESP_EXPOSE_MEM_EN adds the mem_o port mirroring the
// whole memory array.
module lsu_mem_responder
    import lsu_mem_pkg::*;
#(
    parameter int NUM_WORDS = LSU_NUM_WORDS,
    parameter int DATA_W    = LSU_DATA_W,
    parameter int ADDR_W    = LSU_ADDR_W,
    parameter int LAT_W     = LSU_LAT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_be_i,
    input  logic [LAT_W-1:0]      lat_i,
    output logic                  load_mem_resp_o,
    output logic                  store_mem_resp_o,
    output logic [DATA_W-1:0]     load_rdata_o,
    output logic                  err_o
`ifdef LSU_MEM_RESP_EXPOSE_MEM_EN
    ,
    output logic [NUM_WORDS*DATA_W-1:0] mem_o
`endif
);

    localparam int BE_W    = DATA_W / 8;
    localparam int IDX_W   = $clog2(NUM_WORDS);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W + BE_W + LAT_W;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_WORDS * 4);

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;

    logic               head_we;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;
    logic [BE_W-1:0]    head_be;
    logic [LAT_W-1:0]   head_lat;
    logic               head_fault;
    logic [IDX_W-1:0]   head_idx;

    lsu_state_t         state;
    lsu_state_t         state_nxt;
    logic [LAT_W-1:0]   cnt;
    logic [LAT_W-1:0]   cnt_nxt;

    logic [DATA_W-1:0]  mem [NUM_WORDS];

    // Ready depends only on registered occupancy, never on a same-cycle pop,
    // and is held low while reset is applied.
    assign req_ready_o = !rst_i && !fifo_full;
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (state == RESP);
    assign entry_in    = {req_we_i, req_addr_i, req_wdata_i, req_be_i, lat_i};

    lsu_req_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (entry_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_we, head_addr, head_wdata, head_be, head_lat} = head;

    assign head_fault = (head_addr[1:0] != 2'b00) || (head_addr >= ADDR_LIMIT);
    assign head_idx   = head_addr[2 +: IDX_W];

    // Head FSM state and latency counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. The counter value 0 covers the first cycle the head
    // is valid, so from IDLE a zero-latency head moves straight to RESP and
    // responds on the edge after acceptance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, WAIT: begin
                if (!fifo_empty) begin
                    if (cnt == head_lat) begin
                        state_nxt = RESP;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = cnt + LAT_W'(1);
                    end
                end
            end
            RESP: begin
                // After the pop an entry remains if the queue was full or a
                // request is being accepted in this same cycle.
                state_nxt = (fifo_full || push) ? WAIT : IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Memory array: zeroed by reset, stores commit at the end of RESP so a
    // later queued load sees them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && head_we && !head_fault) begin
            mem[head_idx] <= be_merge(mem[head_idx], head_wdata, head_be);
        end
    end

    assign load_mem_resp_o  = pop && !head_we;
    assign store_mem_resp_o = pop && head_we;
    assign err_o            = pop && head_fault;
    assign load_rdata_o     = (pop && !head_we && !head_fault) ? mem[head_idx] : '0;

`ifdef LSU_MEM_RESP_EXPOSE_MEM_EN
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_mem_o
        assign mem_o[g*DATA_W +: DATA_W] = mem[g];
    end
`endif

endmodule
